regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port integer register file with a per-register pending-write scoreboard.
//  Sits in the decode/writeback boundary of the pipelined core:
//    - decode reads operands and their busy flags, and reserves its destination;
//    - writeback writes the result and releases the reservation.
//  Register 0 is hardwired to zero and is never busy.
// PARAMETERS
//  XLEN   32  data width of each register
//  NREG   32  number of architectural registers (power of two, >=2)
//  NREAD  2   number of independent read ports (>=1)
//  AW     $clog2(NREG)  register index width (derived, do not override)
// PORTS
//  clk        in   1          clock, all state updates on rising edge
//  rst_n      in   1          synchronous active-low reset
//  wen        in   1          write enable (writeback)
//  dsel       in   AW         write register index
//  d          in   XLEN       write data
//  rsel       in   NREAD*AW   read indices, port i at [i*AW +: AW]
//  rdata      out  NREAD*XLEN read data, port i at [i*XLEN +: XLEN]
//  rbusy      out  NREAD      port i register has a pending (reserved) write
//  resv_en    in   1          reserve destination (decode)
//  resv_sel   in   AW         register index to reserve
//  resv_err   out  1          sticky: reserve issued to an already-busy register
// BEHAVIOUR
//  - Reset: the synchronous active-low reset rst_n is sampled on clk rising edge.
//    While low, all registers go to 0, all busy bits to 0 and resv_err to 0.
//    Reset overrides wen/resv_en in the same cycle.
//  - Reads are combinational (zero latency) from current state. rsel==0 -> rdata=0, rbusy=0.
//  - Write: on the edge with wen=1 and dsel!=0, reg[dsel] <= d and busy[dsel] <= 0.
//    wen with dsel==0 is ignored.
//  - Reserve: on the edge with resv_en=1 and resv_sel!=0, busy[resv_sel] <= 1.
//    resv_sel==0 is ignored.
//  - Simultaneous write and reserve to the same index: data is written AND busy ends at 1
//    (the new producer wins).
//  - Reserve to a register whose busy bit is already 1 (and not released by a same-cycle
//    write) sets resv_err <= 1. resv_err stays set until reset.
//  - Multiple read ports may select the same index; all return identical values.
//  - Out-of-range indices cannot occur (NREG is a power of two).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - a read port with rsel==dsel!=0 while wen=1 returns d combinationally and rbusy=0
//      (write-through, same cycle).
//    - Bypass is not applied when a same-cycle reserve hits that index; rbusy still reads 0
//      in that cycle.
//  REGFILE_BYPASS_EN undefined:
//    - reads return the stored value and the stored busy flag until the edge;
//      the new value is visible from the next cycle.
// STRUCTURE
//  - regfile_pkg holds:
//    - XLEN_DEF and NREG_DEF constants;
//    - typedef reg_idx_t (AW bits) and xword_t (XLEN bits);
//    - constant ZERO_REG = 0.
//  - One sub-module, regfile_scoreboard:
//    - owns busy[NREG-1:0] and resv_err;
//    - inputs: clk, rst_n, wen, dsel, resv_en, resv_sel;
//    - exposes the busy vector for per-port rbusy muxing.
//  - The data array and read muxes live in regfile_sb, with a generate loop over NREAD ports.
// TESTING
//  1. rst_n=0 one edge, then rst_n=1:
//     - all rsel 0..31 -> rdata=0, rbusy=0, resv_err=0.
//  2. Write x0 protection and basic write:
//     - wen=1, dsel=0, d=32'h1234 -> rsel0=0 reads 0;
//     - then dsel=1, d=32'h1234 -> next cycle rsel0=1 reads 32'h1234.
//  3. Write with wen=0:
//     - dsel=2, d=32'hDEAD -> x2 stays 0;
//     - x1 still reads 32'h1234 on both ports.
//  4. Scoreboard:
//     - resv_en=1, resv_sel=5 -> rbusy=1 for rsel=5 next cycle;
//     - wen=1, dsel=5, d=32'hA5A5 -> next cycle rbusy=0, rdata=32'hA5A5;
//     - reserve 5 twice without write -> resv_err=1, held until reset.
//  5. Same-cycle write+reserve on x7 -> next cycle rdata=d, rbusy=1, resv_err unchanged.
//  6. Bypass:
//     - wen=1, dsel=3, d=32'hBEEF, rsel=3 in same cycle;
//     - with REGFILE_BYPASS_EN -> rdata=32'hBEEF immediately;
//     - without -> old value, 32'hBEEF after the edge.
//  Also: a mid-sequence rst_n=0 with pending reservations clears all busy bits and data next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file with pending-write scoreboard.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-through on the read ports.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker: decode reserves a destination, writeback releases it.
// A reserve that lands on a register that is still busy raises the sticky resv_err flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wen,
    input  logic [AW-1:0]   dsel,
    input  logic            resv_en,
    input  logic [AW-1:0]   resv_sel,
    output logic [NREG-1:0] busy,
    output logic            resv_err
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic            err_q;
    logic            err_nxt;
    logic            wr_ok;
    logic            rv_ok;
    logic            rv_collide;

    assign wr_ok = wen && (dsel != AW'(ZERO_REG));
    assign rv_ok = resv_en && (resv_sel != AW'(ZERO_REG));

    // A write to the same index in the same cycle releases the old producer first.
    assign rv_collide = rv_ok && busy_q[resv_sel] && !(wr_ok && (dsel == resv_sel));

    always_comb begin
        busy_nxt = busy_q;
        err_nxt  = err_q;
        if (wr_ok) begin
            busy_nxt[dsel] = 1'b0;
        end
        if (rv_ok) begin
            busy_nxt[resv_sel] = 1'b1;
        end
        if (rv_collide) begin
            err_nxt = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            err_q  <= err_nxt;
        end
    end

    assign busy     = busy_q;
    assign resv_err = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file (x0 hardwired to zero) with a pending-write scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writeback data to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [AW-1:0]         dsel,
    input  logic [XLEN-1:0]       d,
    input  logic [NREAD*AW-1:0]   rsel,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  resv_en,
    input  logic [AW-1:0]         resv_sel,
    output logic                  resv_err
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            wr_ok;

    assign wr_ok = wen && (dsel != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_ok) begin
            regs[dsel] <= d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .dsel     (dsel),
        .resv_en  (resv_en),
        .resv_sel (resv_sel),
        .busy     (busy),
        .resv_err (resv_err)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   sel;
        logic [XLEN-1:0] rd_val;
        logic            rd_busy;

        assign sel = rsel[i*AW +: AW];

        always_comb begin
            rd_val  = regs[sel];
            rd_busy = busy[sel];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed when a new producer reserves the same register.
            if (wr_ok && (dsel == sel)) begin
                rd_busy = 1'b0;
                if (!(resv_en && (resv_sel == sel))) begin
                    rd_val = d;
                end
            end
`endif
            if (sel == AW'(ZERO_REG)) begin
                rd_val  = '0;
                rd_busy = 1'b0;
            end
        end

        assign rdata[i*XLEN +: XLEN] = rd_val;
        assign rbusy[i]              = rd_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against a
// behavioural model of the register file and its reservation table.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN  = XLEN_DEF;
    localparam int NREG  = NREG_DEF;
    localparam int NREAD = 2;
    localparam int AW    = $clog2(NREG);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wen;
    logic [AW-1:0]         dsel;
    logic [XLEN-1:0]       d;
    logic [NREAD*AW-1:0]   rsel;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  resv_en;
    logic [AW-1:0]         resv_sel;
    logic                  resv_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] mreg  [NREG];
    logic            mbusy [NREG];
    logic            merr;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .dsel     (dsel),
        .d        (d),
        .rsel     (rsel),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .resv_en  (resv_en),
        .resv_sel (resv_sel),
        .resv_err (resv_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int s);
        if (s == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wen && int'(dsel) == s && !(resv_en && int'(resv_sel) == s)) return d;
`endif
        return mreg[s];
    endfunction

    function automatic logic exp_busy(input int s);
        if (s == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wen && int'(dsel) == s) return 1'b0;
`endif
        return mbusy[s];
    endfunction

    // Reference behaviour applied at each rising edge from the inputs held across it.
    task automatic model_update();
        int ds, rs;
        logic wr, rv;
        ds = int'(dsel);
        rs = int'(resv_sel);
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                mreg[k]  = '0;
                mbusy[k] = 1'b0;
            end
            merr = 1'b0;
            return;
        end
        wr = wen && ds != 0;
        rv = resv_en && rs != 0;
        if (rv && mbusy[rs] && !(wr && ds == rs)) merr = 1'b1;
        if (wr) begin
            mreg[ds]  = d;
            mbusy[ds] = 1'b0;
        end
        if (rv) mbusy[rs] = 1'b1;
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < NREAD; p++) begin
            int s;
            s = int'(rsel[p*AW +: AW]);
            chk({tag, "_rdata"}, 64'(rdata[p*XLEN +: XLEN]), 64'(exp_data(s)));
            chk({tag, "_rbusy"}, 64'(rbusy[p]), 64'(exp_busy(s)));
        end
        chk({tag, "_err"}, 64'(resv_err), 64'(merr));
    endtask

    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_rsel(input int p, input int v);
        rsel[p*AW +: AW] = AW'(v);
    endtask

    task automatic idle();
        wen = 1'b0; dsel = '0; d = '0; resv_en = 1'b0; resv_sel = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        rsel  = '0;
        idle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state across every index
        for (int s = 0; s < NREG; s++) begin
            set_rsel(0, s);
            set_rsel(1, NREG - 1 - s);
            #1;
            chk("rst_rdata0", 64'(rdata[0 +: XLEN]), 64'd0);
            chk("rst_rbusy", 64'(rbusy), 64'd0);
            cycle("rst");
        end
        chk("rst_err", 64'(resv_err), 64'd0);

        // x0 protection and basic write
        wen = 1'b1; dsel = 0; d = 32'h1234; set_rsel(0, 0); set_rsel(1, 0);
        cycle("wx0");
        wen = 1'b0;
        #1 chk("x0_zero", 64'(rdata[0 +: XLEN]), 64'd0);
        wen = 1'b1; dsel = 1; d = 32'h1234;
        cycle("wx1");
        idle(); set_rsel(0, 1); set_rsel(1, 1);
        #1;
        chk("x1_p0", 64'(rdata[0 +: XLEN]), 64'h1234);
        chk("x1_p1", 64'(rdata[XLEN +: XLEN]), 64'h1234);

        // Write with wen low has no effect
        dsel = 2; d = 32'hDEAD;
        cycle("nowen");
        set_rsel(0, 2);
        #1;
        chk("x2_zero", 64'(rdata[0 +: XLEN]), 64'd0);
        chk("x1_keep", 64'(rdata[XLEN +: XLEN]), 64'h1234);
        idle();

        // Reserve then release
        resv_en = 1'b1; resv_sel = 5;
        cycle("rv5");
        idle(); set_rsel(0, 5);
        #1 chk("x5_busy", 64'(rbusy[0]), 64'd1);
        wen = 1'b1; dsel = 5; d = 32'hA5A5;
        cycle("wr5");
        idle();
        #1;
        chk("x5_free", 64'(rbusy[0]), 64'd0);
        chk("x5_data", 64'(rdata[0 +: XLEN]), 64'hA5A5);

        // Same-cycle write and reserve: new producer wins, no error
        wen = 1'b1; dsel = 7; d = 32'hCAFEF00D; resv_en = 1'b1; resv_sel = 7; set_rsel(0, 7);
        cycle("wrv7");
        idle();
        #1;
        chk("x7_data", 64'(rdata[0 +: XLEN]), 64'hCAFEF00D);
        chk("x7_busy", 64'(rbusy[0]), 64'd1);
        chk("x7_err", 64'(resv_err), 64'd0);
        // Re-reserve a busy register released by the same-cycle write: still no error
        wen = 1'b1; dsel = 7; d = 32'h77; resv_en = 1'b1; resv_sel = 7;
        cycle("wrv7b");
        idle();
        #1 chk("x7b_err", 64'(resv_err), 64'd0);

        // Double reserve raises sticky error
        resv_en = 1'b1; resv_sel = 5;
        cycle("rv5a");
        cycle("rv5b");
        idle();
        #1 chk("err_set", 64'(resv_err), 64'd1);
        wen = 1'b1; dsel = 5; d = 32'h5;
        cycle("err_hold");
        idle();
        #1 chk("err_sticky", 64'(resv_err), 64'd1);

        // Same-cycle read of the register being written
        wen = 1'b1; dsel = 3; d = 32'hBEEF; set_rsel(0, 3);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_now", 64'(rdata[0 +: XLEN]), 64'hBEEF);
`else
        chk("byp_now", 64'(rdata[0 +: XLEN]), 64'd0);
`endif
        cycle("byp");
        idle();
        #1 chk("byp_after", 64'(rdata[0 +: XLEN]), 64'hBEEF);

        // Mid-sequence reset with pending reservations
        resv_en = 1'b1; resv_sel = 9;
        cycle("rv9");
        idle(); rst_n = 1'b0;
        cycle("mrst");
        rst_n = 1'b1; set_rsel(0, 9); set_rsel(1, 1);
        #1;
        chk("mrst_busy", 64'(rbusy[0]), 64'd0);
        chk("mrst_data", 64'(rdata[XLEN +: XLEN]), 64'd0);
        chk("mrst_err", 64'(resv_err), 64'd0);

        // Randomized traffic on a narrow index range to force collisions
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            wen      = $urandom_range(0, 1);
            dsel     = AW'($urandom_range(0, 7));
            d        = $urandom;
            resv_en  = ($urandom_range(0, 2) == 0);
            resv_sel = AW'($urandom_range(0, 7));
            set_rsel(0, $urandom_range(0, 7));
            set_rsel(1, ($urandom_range(0, 3) == 0) ? int'(dsel) : $urandom_range(0, 7));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
